// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_pkg : shared widths and fetch FSM encoding for the 8-bit CPU    |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
package cpu_pkg;

  localparam int DATA_WIDTH_C = 8;
  localparam int ADDR_WIDTH_C = 8;
  localparam int EXT_BIT_C    = 7;

  localparam logic [2:0] ST_IDLE_C      = 3'd0;
  localparam logic [2:0] ST_FETCH_OP_C  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP_C   = 3'd2;
  localparam logic [2:0] ST_FETCH_ARG_C = 3'd3;
  localparam logic [2:0] ST_WAIT_ARG_C  = 3'd4;
  localparam logic [2:0] ST_HOLD_C      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE_C,
    S_FETCH_OP  = ST_FETCH_OP_C,
    S_WAIT_OP   = ST_WAIT_OP_C,
    S_FETCH_ARG = ST_FETCH_ARG_C,
    S_WAIT_ARG  = ST_WAIT_ARG_C,
    S_HOLD      = ST_HOLD_C
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | program_counter : loadable, incrementing PC with natural wrap       |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module program_counter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ld,
  input  logic [ADDR_WIDTH-1:0] inp,
  output logic [ADDR_WIDTH-1:0] out
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // load wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (ld) begin
      r_pc <= inp;
    end else if (enable) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign out = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_unit : ROM fetch sequencer assembling 1/2-byte instructions   |
// | Rev 1.0 : initial release                                           |
// +--------------------------------------------------------------------+
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_C,
  parameter int ADDR_WIDTH = ADDR_WIDTH_C,
  parameter int EXT_BIT    = EXT_BIT_C
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  halt,
  input  logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  pc_enable,
  output logic                  pc_ld,
  output logic [ADDR_WIDTH-1:0] pc_ld_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  branch_req,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic [ADDR_WIDTH-1:0] instr_addr
);

  fetch_state_t          r_state;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_opcode;
  logic [DATA_WIDTH-1:0] r_operand;
  logic [ADDR_WIDTH-1:0] r_instr_addr;
  logic                  w_fetch;

  assign w_fetch    = (r_state == S_FETCH_OP) || (r_state == S_FETCH_ARG);
  assign mem_addr   = pc_out;
  assign pc_ld_addr = branch_addr;

  // A branch suppresses the fetch strobes so PC never sees ld and enable together
  always_comb begin
    pc_enable = 1'b0;
    pc_ld     = 1'b0;
    mem_rd    = 1'b0;
    if (!reset) begin
      if (branch_req) begin
        pc_ld = 1'b1;
      end else if (w_fetch) begin
        pc_enable = 1'b1;
        mem_rd    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_valid      <= 1'b0;
      r_opcode     <= '0;
      r_operand    <= '0;
      r_instr_addr <= '0;
    end else if (branch_req) begin
      r_valid <= 1'b0;
      r_state <= halt ? S_IDLE : S_FETCH_OP;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!halt) r_state <= S_FETCH_OP;
        end
        S_FETCH_OP: begin
          r_instr_addr <= pc_out;
          r_state      <= S_WAIT_OP;
        end
        S_WAIT_OP: begin
          r_opcode <= mem_data;
          if (mem_data[EXT_BIT]) begin
            r_state <= S_FETCH_ARG;
          end else begin
            r_operand <= '0;
            r_valid   <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_FETCH_ARG: begin
          r_state <= S_WAIT_ARG;
        end
        S_WAIT_ARG: begin
          r_operand <= mem_data;
          r_valid   <= 1'b1;
          r_state   <= S_HOLD;
        end
        S_HOLD: begin
          if (instr_ready) begin
            r_valid <= 1'b0;
            r_state <= halt ? S_IDLE : S_FETCH_OP;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign instr_valid = r_valid;
  assign opcode      = r_opcode;
  assign operand     = r_operand;
  assign instr_addr  = r_instr_addr;

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch sequencer that sits directly downstream of program_counter in the 8-bit microprocessor. It reads the PC value, issues reads to the synchronous program ROM, and pulses pc_enable to advance the PC. It assembles 1- or 2-byte instructions into opcode/operand registers and hands them to the decoder with a valid/ready handshake. It also drives pc_ld for branches.

Parameters:
DATA_WIDTH, 8, width of ROM data, opcode and operand
ADDR_WIDTH, 8, width of PC and ROM address
EXT_BIT, 7, opcode bit that, when 1, marks a 2-byte instruction (operand follows)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
halt  input  1  1 = do not start new fetches
pc_out  input  ADDR_WIDTH  current PC value from program_counter
pc_enable  output  1  increment strobe to program_counter
pc_ld  output  1  load strobe to program_counter
pc_ld_addr  output  ADDR_WIDTH  load value to program_counter
mem_rd  output  1  ROM read strobe
mem_addr  output  ADDR_WIDTH  ROM address, combinationally equal to pc_out
mem_data  input  DATA_WIDTH  ROM data, valid the cycle after mem_rd
branch_req  input  1  1-cycle request to redirect fetch
branch_addr  input  ADDR_WIDTH  branch target
instr_valid  output  1  opcode/operand/instr_addr hold a complete instruction
instr_ready  input  1  decoder accepts the instruction
opcode  output  DATA_WIDTH  latched first byte
operand  output  DATA_WIDTH  latched second byte; 0 for 1-byte instructions
instr_addr  output  ADDR_WIDTH  PC of the opcode byte

Behaviour:
- FSM states: IDLE, FETCH_OP, WAIT_OP, FETCH_ARG, WAIT_ARG, HOLD. Reset enters IDLE immediately (async).
- Reset values: all registered outputs are 0, and instr_valid=0.
- pc_enable, mem_rd, pc_ld and pc_ld_addr are combinational from the state and inputs. pc_enable and pc_ld are never both 1.
- IDLE: no strobes. Next state is FETCH_OP when halt=0.
- FETCH_OP: mem_rd=1, pc_enable=1, and pc_out is captured into instr_addr. Next state is WAIT_OP.
- WAIT_OP: mem_data is latched into opcode.
  - If mem_data[EXT_BIT]=1, next state is FETCH_ARG.
  - Otherwise operand is set to 0 and the next state is HOLD.
- FETCH_ARG: mem_rd=1, pc_enable=1. Next state is WAIT_ARG.
- WAIT_ARG: mem_data is latched into operand. Next state is HOLD.
- HOLD: instr_valid=1, and opcode/operand/instr_addr are stable.
  - On instr_ready=1, the instruction is consumed at the clock edge.
  - After consumption, next state is FETCH_OP if halt=0, else IDLE.
  - When instr_ready=0, the FSM stays in HOLD indefinitely.
- instr_valid is asserted only in HOLD.
- Latency from FETCH_OP entry to instr_valid: 2 cycles for a 1-byte instruction, 4 cycles for a 2-byte instruction. Throughput: one instruction per 3 or 5 cycles with instr_ready held at 1.
- branch_req has priority over everything in every state:
  - Outputs that cycle: pc_ld=1, pc_ld_addr=branch_addr, pc_enable=0, mem_rd=0.
  - Any in-flight ROM data is discarded, and an instruction pending in HOLD is dropped even if instr_ready=1.
  - Next state is FETCH_OP if halt=0, else IDLE.
  - The first fetch after a branch reads from branch_addr.
- halt does not abort a fetch already in progress; it only blocks leaving IDLE and blocks the HOLD→FETCH_OP transition.
- PC wrap from 0xFF to 0x00 is owned by program_counter. A 2-byte opcode at 0xFF takes its operand from 0x00.
- A reset assertion mid-instruction discards the partial instruction. No strobes are issued while reset=1.

Decomposition:
- Shared package cpu_pkg holds the FSM state encoding (localparams), EXT_BIT, and the DATA_WIDTH/ADDR_WIDTH defaults.
- No sub-module: a single FSM plus the opcode/operand/instr_addr registers.
- Integration top wires fetch_unit to program_counter (pc_enable, ld←pc_ld, inp←pc_ld_addr, out→pc_out).

Test Plan:
- Bench model: a 1-cycle-latency ROM with 00:12, 01:85, 02:3C, 03:07, 10:44. program_counter is instantiated as real.
- Reset release with instr_ready=1, halt=0 → first instr_valid 2 cycles after FETCH_OP with opcode=12, operand=00, instr_addr=00. Then opcode=85, operand=3C, instr_addr=01, arriving 4 cycles after its FETCH_OP.
- Backpressure: instr_ready=0 for 6 cycles during HOLD → instr_valid and all outputs stay constant, no pc_enable pulses, and the PC holds at 01. On release, fetching resumes at 01.
- branch_req=1 with branch_addr=10 asserted during WAIT_ARG → pc_ld=1 for 1 cycle and the partial 85 instruction is dropped. Next instr_valid shows opcode=44, instr_addr=10.
- halt=1 asserted in HOLD → after the instr_ready handshake the FSM goes to IDLE with zero strobes for 10 cycles. halt=0 → fetching resumes at the PC value.
- Async reset mid-FETCH_ARG (between clock edges) → instr_valid=0, opcode=0, and all strobes 0 immediately. After release, fetching restarts at 00 with opcode=12.
- Check pc_enable & pc_ld never both 1 in any cycle. Check mem_addr==pc_out whenever mem_rd=1.
